coherence_bus_ctrl: RTL and testbench
=====================================

# coherence_bus_ctrl

Snooping bus controller for the dual-core design. It is the responder side of the dcache/icache coherence interface. It arbitrates dcache read misses, writebacks and write-upgrades (ccwrite), plus icache fetches, from two cores onto one RAM port. It drives dwait/dload/ccwait/ccinv/ccsnoopaddr back to the caches and performs cache-to-cache transfers when a snooped block is dirty.

## Interface
- CPUS, 2, number of cores; fixed at 2 in this revision.
- CLK  in  1  system clock.
- nRST  in  1  asynchronous, active-low reset.
- dREN, dWEN, ccwrite  in  [1:0]  per-cache data read / writeback / write-upgrade requests.
- daddr, dstore  in  [1:0][31:0]  per-cache word address and store data.
- cctrans  in  [1:0]  snooped cache holds the block valid+dirty and is supplying dstore.
- iREN  in  [1:0]; iaddr  in  [1:0][31:0]  instruction fetch.
- dwait, iwait  out  [1:0]  stall; low for exactly the cycle a word completes.
- dload, iload  out  [1:0][31:0]  returned data.
- ccwait, ccinv  out  [1:0]  snoop strobe / invalidate-or-upgrade-ack.
- ccsnoopaddr  out  [1:0][31:0]  snoop address.
- ramREN, ramWEN  out  1; ramaddr, ramstore  out  32.
- ramload  in  32; ramstate  in  2  (FREE=0, BUSY=1, ACCESS=2, ERROR=3).

## Operation
- States: IDLE, WB1, WB2, SNOOP1, SNOOP2, XFER1, XFER2, INV, IFETCH.
- Requester `r` is latched in IDLE; snooper `s = ~r`. A round-robin bit `last` (reset 0) prefers the cache not served last when both request the same class.
- IDLE priority: dWEN → WB1; else dREN → SNOOP1; else ccwrite → INV; else iREN → IFETCH; else stay.
- WB1/WB2: ramWEN=1, ramaddr=daddr[r], ramstore=dstore[r]. On ramstate==ACCESS: dwait[r]=0, advance WB1→WB2→IDLE.
- SNOOP1/SNOOP2: ccwait[s]=1, ccsnoopaddr[s]=daddr[r] with word-offset bit forced 0, ccinv[s]=ccwrite[r] (read-exclusive). Held two cycles because the cache registers ccsnoopaddr. At the end of SNOOP2, latch `c2c = cctrans[s]` and go to XFER1.
- XFER1/XFER2 (word offset bit 0 then 1): ccwait[s] and ccsnoopaddr[s] are held, with the offset bit reflecting the current word.
  - If c2c: dload[r]=dstore[s], ramWEN=1, ramstore=dstore[s], ramaddr=daddr[r].
  - Else: ramREN=1, ramaddr=daddr[r], dload[r]=ramload.
  - dwait[r]=0 on ACCESS. XFER2 then → IDLE.
- INV: one cycle. ccwait[s]=1, ccinv[s]=1, ccsnoopaddr[s]=daddr[r], ccinv[r]=1 (upgrade ack). → IDLE.
- IFETCH: ramREN=1, ramaddr=iaddr[r], iload[r]=ramload, iwait[r]=0 on ACCESS → IDLE.
- `last` updates to `r` on every return to IDLE.
- ramstate BUSY or ERROR: hold state, keep wait high.

## Timing
- All outputs are combinational from state, the latched r/c2c, and ramstate. No registered outputs.
- Reset: state=IDLE; dwait=iwait=2'b11; all other outputs 0.
- Best-case latency (RAM ACCESS in the first cycle):
  - writeback: 2 cycles.
  - read miss: 4 cycles (2 snoop + 2 data).
  - upgrade: 1 cycle.
  - ifetch: 1 cycle.
- A request deasserted mid-transaction is ignored: the controller completes the block.
- Simultaneous dREN[0] and dREN[1]: served serially by round-robin; the loser sees dwait high throughout.
- Reset mid-transaction aborts immediately to IDLE. No partial RAM write is retried.

## Configuration
- BUSCTRL_C2C_EN defined: behaviour as above. A dirty snoop supplies the requester directly while RAM is updated in parallel.
- Undefined: when c2c is set, XFER1/XFER2 only write dstore[s] to RAM with dwait[r] held high. The FSM then re-enters XFER1/XFER2 with c2c cleared and reads from RAM. Read-miss latency rises to 6 cycles, and the data delivered is identical.

## Test plan
- Reset, then idle with ramstate=FREE: dwait=2'b11, iwait=2'b11, ramREN=ramWEN=0, ccwait=0.
- Cache0 dREN at 0x100; cache1 cctrans=0; ramload=0xDEAD then 0xBEEF: ccwait[1]=1 for 2 cycles; dload[0]=0xDEAD with dwait[0]=0 at ramaddr 0x100, then 0xBEEF at 0x104.
- Cache1 dREN at 0x200, ccwrite=1; cache0 cctrans=1, dstore=0x1234/0x5678: ccinv[0]=1; dload[1]=0x1234/0x5678; ramWEN=1 writes both words to 0x200/0x204. Without BUSCTRL_C2C_EN, the RAM write occurs first and the read-back follows.
- Cache0 ccwrite at 0x300: a single cycle with ccinv[0]=1, ccinv[1]=1, ccsnoopaddr[1]=0x300.
- Both dWEN in the same cycle, last=0: cache1 writes back first (2 words), then cache0. Each dwait goes low once per ACCESS.
- ramstate=BUSY for 3 cycles during WB1: state holds, dwait[r]=1, ramWEN stays 1; completion follows on ACCESS.

Source files
------------

// File: rtl/coherence_bus_ctrl.sv
// ---------------------------------------------------------------------------
// coherence_bus_ctrl
//
// Snooping bus controller for the dual-core design. It is the responder side
// of the dcache/icache coherence interface. Dcache writebacks, read misses
// and write-upgrades, plus icache fetches, from both cores share one RAM
// port. A read miss first snoops the other cache. If that cache holds the
// block dirty, its data is forwarded (cache-to-cache) and RAM is updated.
//
// Optional feature macro: BUSCTRL_C2C_EN
//   defined   : a dirty snoop feeds the requester directly while RAM is
//               written in parallel (4-cycle best-case read miss).
//   undefined : the dirty block is written to RAM first, then the same two
//               words are read back from RAM (6-cycle best-case read miss).
//
// Ports
//   CLK, nRST              clock, asynchronous active-low reset
//   dREN/dWEN/ccwrite      per-cache read miss / writeback / upgrade request
//   daddr, dstore          per-cache word address and store data
//   cctrans                snooped cache is supplying a valid+dirty block
//   iREN, iaddr            per-cache instruction fetch
//   dwait/iwait            stall, low for the cycle a word completes
//   dload/iload            returned data
//   ccwait/ccinv           snoop strobe / invalidate (or upgrade ack)
//   ccsnoopaddr            snoop address
//   ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate   RAM port
// ---------------------------------------------------------------------------
module coherence_bus_ctrl #(
   parameter int CPUS = 2
) (
   input  logic                      CLK,
   input  logic                      nRST,
   input  logic [CPUS-1:0]           dREN,
   input  logic [CPUS-1:0]           dWEN,
   input  logic [CPUS-1:0]           ccwrite,
   input  logic [CPUS-1:0][31:0]     daddr,
   input  logic [CPUS-1:0][31:0]     dstore,
   input  logic [CPUS-1:0]           cctrans,
   input  logic [CPUS-1:0]           iREN,
   input  logic [CPUS-1:0][31:0]     iaddr,
   output logic [CPUS-1:0]           dwait,
   output logic [CPUS-1:0]           iwait,
   output logic [CPUS-1:0][31:0]     dload,
   output logic [CPUS-1:0][31:0]     iload,
   output logic [CPUS-1:0]           ccwait,
   output logic [CPUS-1:0]           ccinv,
   output logic [CPUS-1:0][31:0]     ccsnoopaddr,
   output logic                      ramREN,
   output logic                      ramWEN,
   output logic [31:0]               ramaddr,
   output logic [31:0]               ramstore,
   input  logic [31:0]               ramload,
   input  logic [1:0]                ramstate
);

   localparam logic [1:0] RAM_ACCESS = 2'd2;

   typedef enum logic [3:0] {
      IDLE, WB1, WB2, SNOOP1, SNOOP2, XFER1, XFER2, INV, IFETCH
   } state_t;

   state_t      state, next_state;
   logic        r, next_r;
   logic        c2c, next_c2c;
   logic        last, next_last;
   logic        s;
   logic        access;
   logic [31:0] rd_addr;

   assign s       = ~r;
   assign access  = (ramstate == RAM_ACCESS);
   assign rd_addr = daddr[r];

   // When both caches raise the same request class, the one not served
   // most recently wins; otherwise the single requester is chosen.
   function automatic logic pick(input logic [1:0] req, input logic pref);
      return (req == 2'b11) ? pref : req[1];
   endfunction

   // State register plus the latched requester, the dirty-snoop flag and
   // the round-robin history. Reset drops any transaction in flight.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
         r     <= 1'b0;
         c2c   <= 1'b0;
         last  <= 1'b0;
      end else begin
         state <= next_state;
         r     <= next_r;
         c2c   <= next_c2c;
         last  <= next_last;
      end
   end

   // Next-state and all outputs. Outputs are purely combinational from the
   // state, latched requester/c2c and ramstate. RAM beats only advance on
   // ACCESS, so BUSY/ERROR simply hold the state with the wait line high.
   always_comb begin
      next_state  = state;
      next_r      = r;
      next_c2c    = c2c;
      next_last   = last;
      dwait       = '1;
      iwait       = '1;
      dload       = '0;
      iload       = '0;
      ccwait      = '0;
      ccinv       = '0;
      ccsnoopaddr = '0;
      ramREN      = 1'b0;
      ramWEN      = 1'b0;
      ramaddr     = '0;
      ramstore    = '0;

      case (state)
         IDLE: begin
            if (|dWEN) begin
               next_r     = pick(dWEN, ~last);
               next_state = WB1;
            end else if (|dREN) begin
               next_r     = pick(dREN, ~last);
               next_state = SNOOP1;
            end else if (|ccwrite) begin
               next_r     = pick(ccwrite, ~last);
               next_state = INV;
            end else if (|iREN) begin
               next_r     = pick(iREN, ~last);
               next_state = IFETCH;
            end
         end

         WB1, WB2: begin
            ramWEN   = 1'b1;
            ramaddr  = rd_addr;
            ramstore = dstore[r];
            if (access) begin
               dwait[r]   = 1'b0;
               next_state = (state == WB1) ? WB2 : IDLE;
            end
         end

         // The snooped cache registers ccsnoopaddr, so the strobe is held
         // for two cycles before its cctrans answer is trusted.
         SNOOP1, SNOOP2: begin
            ccwait[s]      = 1'b1;
            ccinv[s]       = ccwrite[r];
            ccsnoopaddr[s] = {rd_addr[31:3], 1'b0, rd_addr[1:0]};
            if (state == SNOOP1) begin
               next_state = SNOOP2;
            end else begin
               next_c2c   = cctrans[s];
               next_state = XFER1;
            end
         end

         XFER1, XFER2: begin
            ccwait[s]      = 1'b1;
            ccsnoopaddr[s] = {rd_addr[31:3], (state == XFER2), rd_addr[1:0]};
            ramaddr        = rd_addr;
            if (c2c) begin
               ramWEN   = 1'b1;
               ramstore = dstore[s];
`ifdef BUSCTRL_C2C_EN
               dload[r] = dstore[s];
               if (access) dwait[r] = 1'b0;
`endif
            end else begin
               ramREN   = 1'b1;
               dload[r] = ramload;
               if (access) dwait[r] = 1'b0;
            end
            if (access) begin
               if (state == XFER1) begin
                  next_state = XFER2;
               end else begin
`ifdef BUSCTRL_C2C_EN
                  next_state = IDLE;
`else
                  // Without forwarding, the dirty block has only been
                  // written back; re-run both words as a RAM read.
                  if (c2c) begin
                     next_c2c   = 1'b0;
                     next_state = XFER1;
                  end else begin
                     next_state = IDLE;
                  end
`endif
               end
            end
         end

         INV: begin
            ccwait[s]      = 1'b1;
            ccinv[s]       = 1'b1;
            ccsnoopaddr[s] = rd_addr;
            ccinv[r]       = 1'b1;
            next_state     = IDLE;
         end

         IFETCH: begin
            ramREN   = 1'b1;
            ramaddr  = iaddr[r];
            iload[r] = ramload;
            if (access) begin
               iwait[r]   = 1'b0;
               next_state = IDLE;
            end
         end

         default: next_state = IDLE;
      endcase

      if (state != IDLE && next_state == IDLE) next_last = r;
   end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_coherence_bus_ctrl
//
// Self-checking bench for coherence_bus_ctrl. The reference model describes
// every transaction as a queue of bus beats (writeback words, snoop cycles,
// forwarded/written/read data words, invalidate, fetch) and predicts every
// output on every cycle from the beat at the head of the queue. RAM beats
// retire only on ACCESS. Directed cases come first, then randomized traffic.
// ---------------------------------------------------------------------------
module tb_coherence_bus_ctrl;

   localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACCESS = 2'd2, RS_ERROR = 2'd3;
   localparam int P_IDLE = 0, P_WB = 1, P_SNOOP = 2, P_C2C = 3, P_C2CWR = 4,
                  P_RD = 5, P_INV = 6, P_IF = 7;

   typedef struct {
      int kind;
      int word;
      bit ram;
   } phase_t;

   logic             CLK = 1'b0;
   logic             nRST;
   logic [1:0]       dREN, dWEN, ccwrite, cctrans, iREN;
   logic [1:0][31:0] daddr, dstore, iaddr;
   logic [1:0]       dwait, iwait, ccwait, ccinv;
   logic [1:0][31:0] dload, iload, ccsnoopaddr;
   logic             ramREN, ramWEN;
   logic [31:0]      ramaddr, ramstore, ramload;
   logic [1:0]       ramstate;

   int          checks = 0;
   int          errors = 0;
   logic        mLast;
   logic [31:0] base [2];
   logic        useFixed;
   logic [31:0] fixedWord [2];
   int          busyLeft;

   coherence_bus_ctrl #(.CPUS(2)) dut (
      .CLK(CLK), .nRST(nRST),
      .dREN(dREN), .dWEN(dWEN), .ccwrite(ccwrite), .daddr(daddr), .dstore(dstore),
      .cctrans(cctrans), .iREN(iREN), .iaddr(iaddr),
      .dwait(dwait), .iwait(iwait), .dload(dload), .iload(iload),
      .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate)
   );

   always #5 CLK = ~CLK;

   // Safety net in case the design wedges in a way no bounded loop catches.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Predict all outputs for one beat and compare them.
   task automatic checkCycle(input string tag, input int kind, input int word, input logic rr);
      logic [1:0]       eDwait, eIwait, eCcwait, eCcinv;
      logic [1:0][31:0] eDload, eIload, eSnoop;
      logic             eRen, eWen, ss, acc;
      logic [31:0]      eAddr, eStore, wAddr;
      ss    = ~rr;
      acc   = (ramstate == RS_ACCESS);
      wAddr = base[rr] | (32'(word) << 2);
      eDwait = 2'b11; eIwait = 2'b11; eCcwait = '0; eCcinv = '0;
      eDload = '0; eIload = '0; eSnoop = '0;
      eRen = 1'b0; eWen = 1'b0; eAddr = '0; eStore = '0;
      case (kind)
         P_WB: begin
            eWen = 1'b1; eAddr = wAddr; eStore = dstore[rr];
            if (acc) eDwait[rr] = 1'b0;
         end
         P_SNOOP: begin
            eCcwait[ss] = 1'b1; eSnoop[ss] = base[rr]; eCcinv[ss] = ccwrite[rr];
         end
         P_C2C, P_C2CWR: begin
            eCcwait[ss] = 1'b1; eSnoop[ss] = wAddr;
            eWen = 1'b1; eAddr = wAddr; eStore = dstore[ss];
            if (kind == P_C2C) begin
               eDload[rr] = dstore[ss];
               if (acc) eDwait[rr] = 1'b0;
            end
         end
         P_RD: begin
            eCcwait[ss] = 1'b1; eSnoop[ss] = wAddr;
            eRen = 1'b1; eAddr = wAddr; eDload[rr] = ramload;
            if (acc) eDwait[rr] = 1'b0;
         end
         P_INV: begin
            eCcwait[ss] = 1'b1; eCcinv[ss] = 1'b1; eSnoop[ss] = base[rr]; eCcinv[rr] = 1'b1;
         end
         P_IF: begin
            eRen = 1'b1; eAddr = iaddr[rr]; eIload[rr] = ramload;
            if (acc) eIwait[rr] = 1'b0;
         end
         default: ;
      endcase
      checkOutput({tag, ".dwait"}, 64'(dwait), 64'(eDwait));
      checkOutput({tag, ".iwait"}, 64'(iwait), 64'(eIwait));
      checkOutput({tag, ".dload"}, dload, eDload);
      checkOutput({tag, ".iload"}, iload, eIload);
      checkOutput({tag, ".ccwait"}, 64'(ccwait), 64'(eCcwait));
      checkOutput({tag, ".ccinv"}, 64'(ccinv), 64'(eCcinv));
      checkOutput({tag, ".ccsnoopaddr"}, ccsnoopaddr, eSnoop);
      checkOutput({tag, ".ramREN"}, 64'(ramREN), 64'(eRen));
      checkOutput({tag, ".ramWEN"}, 64'(ramWEN), 64'(eWen));
      checkOutput({tag, ".ramaddr"}, 64'(ramaddr), 64'(eAddr));
      checkOutput({tag, ".ramstore"}, 64'(ramstore), 64'(eStore));
   endtask

   // Round-robin rule: a lone requester wins; with two, the one not served last.
   function automatic logic pickModel(input logic [1:0] req);
      if (req == 2'b11) return ~mLast;
      return (req == 2'b10);
   endfunction

   // Serve the highest-priority pending request, beat by beat, then drop the
   // served request and check the controller is back to idle.
   task automatic runOne(input string tag);
      phase_t q[$];
      phase_t p;
      int     cls, cyc, rs;
      logic   rr, ss, dirty;
      if (dWEN != 2'b00)         begin cls = 0; rr = pickModel(dWEN);    end
      else if (dREN != 2'b00)    begin cls = 1; rr = pickModel(dREN);    end
      else if (ccwrite != 2'b00) begin cls = 2; rr = pickModel(ccwrite); end
      else                       begin cls = 3; rr = pickModel(iREN);    end
      ss    = ~rr;
      dirty = cctrans[ss];
      case (cls)
         0: begin q.push_back('{P_WB, 0, 1'b1}); q.push_back('{P_WB, 1, 1'b1}); end
         1: begin
            q.push_back('{P_SNOOP, 0, 1'b0}); q.push_back('{P_SNOOP, 0, 1'b0});
            if (dirty) begin
`ifdef BUSCTRL_C2C_EN
               q.push_back('{P_C2C, 0, 1'b1}); q.push_back('{P_C2C, 1, 1'b1});
`else
               q.push_back('{P_C2CWR, 0, 1'b1}); q.push_back('{P_C2CWR, 1, 1'b1});
               q.push_back('{P_RD, 0, 1'b1}); q.push_back('{P_RD, 1, 1'b1});
`endif
            end else begin
               q.push_back('{P_RD, 0, 1'b1}); q.push_back('{P_RD, 1, 1'b1});
            end
         end
         2: q.push_back('{P_INV, 0, 1'b0});
         default: q.push_back('{P_IF, 0, 1'b1});
      endcase
      cyc = 0;
      while (q.size() > 0 && cyc < 100) begin
         @(posedge CLK); #1;
         p = q[0];
         if (p.kind == P_SNOOP) daddr[rr] = base[rr] | ($urandom & 32'h4);
         else if (p.kind == P_INV || p.kind == P_IF) daddr[rr] = base[rr];
         else daddr[rr] = base[rr] | (32'(p.word) << 2);
         dstore[0] = $urandom; dstore[1] = $urandom;
         ramload   = useFixed ? fixedWord[p.word] : $urandom;
         if (useFixed) dstore[ss] = fixedWord[p.word];
         if (p.ram && busyLeft > 0) begin
            ramstate = RS_BUSY;
            busyLeft--;
         end else if (p.ram && useFixed) begin
            ramstate = RS_ACCESS;
         end else begin
            rs = $urandom_range(0, 5);
            ramstate = (rs <= 2) ? RS_ACCESS : (rs == 3) ? RS_FREE : (rs == 4) ? RS_BUSY : RS_ERROR;
         end
         #4;
         checkCycle($sformatf("%s.c%0d", tag, cyc), p.kind, p.word, rr);
         if (!p.ram || ramstate == RS_ACCESS) q.delete(0);
         cyc++;
      end
      checkOutput({tag, ".timeout"}, 64'(q.size()), 64'd0);
      mLast = rr;
      @(posedge CLK); #1;
      case (cls)
         0: dWEN[rr] = 1'b0;
         1: begin dREN[rr] = 1'b0; ccwrite[rr] = 1'b0; end
         2: ccwrite[rr] = 1'b0;
         default: iREN[rr] = 1'b0;
      endcase
      daddr[rr] = base[rr];
      ramstate  = RS_FREE;
      #4;
      checkCycle({tag, ".idle"}, P_IDLE, 0, rr);
   endtask

   task automatic applyStimulus(input string tag, input logic [1:0] wen, input logic [1:0] ren,
                                input logic [1:0] ccw, input logic [1:0] iren, input logic [1:0] ctr,
                                input logic [31:0] b0, input logic [31:0] b1);
      @(posedge CLK); #1;
      base[0] = b0; base[1] = b1;
      daddr[0] = b0; daddr[1] = b1;
      iaddr[0] = b0 ^ 32'h0001_0000; iaddr[1] = b1 ^ 32'h0001_0000;
      dWEN = wen; dREN = ren; ccwrite = ccw; iREN = iren; cctrans = ctr;
      ramstate = RS_FREE;
      #4;
      checkCycle({tag, ".start"}, P_IDLE, 0, 1'b0);
      while ((dWEN | dREN | ccwrite | iREN) != 2'b00) runOne(tag);
   endtask

   initial begin
      nRST = 1'b0;
      dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0; iREN = '0;
      daddr = '0; dstore = '0; iaddr = '0; ramload = '0; ramstate = RS_FREE;
      base[0] = '0; base[1] = '0; mLast = 1'b0; useFixed = 1'b0; busyLeft = 0;
      fixedWord[0] = '0; fixedWord[1] = '0;

      #7;
      checkCycle("reset", P_IDLE, 0, 1'b0);
      @(posedge CLK); #1;
      nRST = 1'b1;
      #4;
      checkCycle("post_reset", P_IDLE, 0, 1'b0);

      // Clean read miss by cache0, data from RAM.
      useFixed = 1'b1;
      fixedWord[0] = 32'h0000_DEAD; fixedWord[1] = 32'h0000_BEEF;
      applyStimulus("rd0", 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 32'h100, 32'h0);

      // Read-exclusive by cache1 hitting a dirty block in cache0.
      fixedWord[0] = 32'h0000_1234; fixedWord[1] = 32'h0000_5678;
      applyStimulus("rdx1", 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 32'h0, 32'h200);

      // Upgrade by cache0.
      applyStimulus("upg0", 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 32'h300, 32'h0);

      // Simultaneous writebacks with last=0: cache1 goes first.
      applyStimulus("wb2", 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 32'h600, 32'h700);

      // Writeback stalled by three BUSY cycles.
      busyLeft = 3;
      applyStimulus("wbbusy", 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 32'h800, 32'h0);

      // Both caches fetch instructions.
      applyStimulus("ifetch", 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 32'h900, 32'hA00);
      useFixed = 1'b0;

      // Reset in the middle of a read miss aborts straight to idle.
      @(posedge CLK); #1;
      base[1] = 32'h500; daddr[1] = 32'h500; cctrans = '0; dREN = 2'b10;
      @(posedge CLK); #1;
      #4;
      checkCycle("midrst.snoop", P_SNOOP, 0, 1'b1);
      @(posedge CLK); #1;
      nRST = 1'b0;
      #4;
      checkCycle("midrst.rst", P_IDLE, 0, 1'b0);
      @(posedge CLK); #1;
      dREN = '0; nRST = 1'b1; mLast = 1'b0;
      #4;
      checkCycle("midrst.after", P_IDLE, 0, 1'b0);

      // Randomized mixed traffic.
      for (int t = 0; t < 40; t++) begin
         applyStimulus($sformatf("rnd%0d", t),
                       ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00,
                       ($urandom_range(0, 1) == 0) ? 2'($urandom) : 2'b00,
                       ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00,
                       ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00,
                       2'($urandom),
                       $urandom & 32'hFFFF_FFF8, $urandom & 32'hFFFF_FFF8);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
